// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store front end for a word-only memory (req_* in, ld_data/ld_valid/req_err/stall out, MemRead/MemWrite/mem_addr/mem_wdata/mem_rdata to memory)
module load_store_unit #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_valid,
  output logic                  req_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t state, state_nx;
  logic [ADR_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_word, ld_ext, merged, bmask, hmask;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  logic [4:0] bsh, hsh;
  logic idle, any, aligned, legal, ld, sw, sub, err;
  assign idle    = state == IDLE;
  assign any     = req_read | req_write;
  assign aligned = req_size == 2'b00 || (req_size == 2'b01 && !req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] == 2'b00);
  assign legal   = (req_read ^ req_write) && aligned;
  assign ld      = idle && legal && req_read;
  assign sw      = idle && legal && req_write && req_size == 2'b10;
  assign sub     = idle && legal && req_write && req_size != 2'b10;
  assign err     = idle && any && !legal;
  assign bsh     = {req_addr[1:0], 3'b000};
  assign hsh     = {req_addr[1], 4'b0000};
  assign byte_l  = mem_rdata[bsh +: 8];
  assign half_l  = mem_rdata[hsh +: 16];
  assign bmask   = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << bsh;
  assign hmask   = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << hsh;
  always_comb begin
    ld_ext    = req_size == 2'b00 ? {{(DATA_WIDTH-8){req_signed & byte_l[7]}}, byte_l} :
                req_size == 2'b01 ? {{(DATA_WIDTH-16){req_signed & half_l[15]}}, half_l} : mem_rdata;
    merged    = req_size == 2'b00 ?
                (mem_rdata & ~bmask) | ({{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]} << bsh) :
                (mem_rdata & ~hmask) | ({{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]} << hsh);
    MemRead   = ld | sub;
    MemWrite  = !idle | sw;
    mem_addr  = idle ? req_addr : rmw_addr;
    mem_wdata = !idle ? rmw_word : sw ? req_wdata : '0;
    stall     = sub;
    state_nx  = sub ? RMW_WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ld_data  <= '0;
      ld_valid <= 1'b0;
      req_err  <= 1'b0;
      rmw_addr <= '0;
      rmw_word <= '0;
    end else begin
      state    <= state_nx;
      ld_valid <= ld;
      req_err  <= err;
      if (ld) ld_data <= ld_ext;
      if (sub) begin
        rmw_addr <= req_addr;
        rmw_word <= merged;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a behavioural word memory
module tb_load_store_unit;
  logic clk = 0, rst = 1;
  logic req_read = 0, req_write = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic stall, ld_valid, req_err, MemRead, MemWrite;
  logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [31:0] a; logic [31:0] d; int c;} ev_t;
  ev_t ldq[$], errq[$], wrq[$], e;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .req_err(req_err), .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = MemRead ? mem[mem_addr[7:2]] : 32'hDEADDEAD;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ld_valid) begin
      if (ldq.size() == 0) chk("unexpected_ld_valid", 1, 0);
      else begin
        e = ldq.pop_front();
        chk("ld_data", ld_data, e.d);
        chk("ld_cycle", cyc, e.c);
      end
    end
    if (req_err) begin
      if (errq.size() == 0) chk("unexpected_req_err", 1, 0);
      else begin
        e = errq.pop_front();
        chk("err_cycle", cyc, e.c);
      end
    end
    if (MemWrite) begin
      if (wrq.size() == 0) chk("unexpected_write", mem_addr, 0);
      else begin
        e = wrq.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic go(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_read = rd; req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] exp);
    go(1, 0, sz, sg, a, 32'h0);
    ldq.push_back('{a, exp, cyc + 1});
    #1;
    chk("ld_memread", MemRead, 1);
    chk("ld_stall", stall, 0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] wd);
    go(0, 1, 2'b10, 0, a, wd);
    wrq.push_back('{a, wd, cyc});
    #1;
    chk("sw_stall", stall, 0);
  endtask

  task automatic sub(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] expw);
    go(0, 1, sz, 0, a, wd);
    wrq.push_back('{a, expw, cyc + 1});
    #1;
    chk("rmw_stall", stall, 1);
    chk("rmw_memread", MemRead, 1);
    chk("rmw_nowrite", MemWrite, 0);
    @(posedge clk);
    #2;
    chk("rmw_wr_stall", stall, 0);
    chk("rmw_wr_memread", MemRead, 0);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
    go(rd, wr, sz, 0, a, 32'h12345678);
    errq.push_back('{a, 0, cyc + 1});
    #1;
    chk("bad_memrw", {MemRead, MemWrite}, 0);
    chk("bad_stall", stall, 0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_read = 0; req_write = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_ld_data", ld_data, 0);
    chk("rst_flags", {ld_valid, req_err, stall, MemRead, MemWrite}, 0);
    chk("rst_wdata", mem_wdata, 0);
    sw(32'h10, 32'h8822F344);
    ld(2'b00, 1, 32'h11, 32'hFFFFFFF3);
    ld(2'b00, 0, 32'h11, 32'h000000F3);
    ld(2'b01, 1, 32'h12, 32'hFFFF8822);
    ld(2'b10, 0, 32'h10, 32'h8822F344);
    sub(2'b00, 32'h11, 32'h000000AB, 32'h8822AB44);
    ld(2'b10, 0, 32'h10, 32'h8822AB44);
    sw(32'h10, 32'h8822F344);
    sub(2'b01, 32'h12, 32'h0000BEEF, 32'hBEEFF344);
    sw(32'h14, 32'hDEADBEEF);
    bad(1, 0, 2'b01, 32'h13);
    bad(0, 1, 2'b10, 32'h12);
    bad(1, 0, 2'b11, 32'h10);
    bad(1, 1, 2'b10, 32'h10);
    ld(2'b10, 0, 32'h10, 32'hBEEFF344);
    ld(2'b10, 0, 32'h14, 32'hDEADBEEF);
    ld(2'b01, 0, 32'h16, 32'h0000DEAD);
    go(0, 1, 2'b00, 0, 32'h10, 32'h00000011);
    rst = 1;
    #1;
    chk("rst_sub_stall", stall, 1);
    @(posedge clk);
    #1;
    rst = 0; req_read = 0; req_write = 0;
    #1;
    chk("rst_sub_nowrite", MemWrite, 0);
    chk("rst_sub_flags", {ld_valid, req_err}, 0);
    chk("rst_sub_ld_data", ld_data, 0);
    ld(2'b10, 0, 32'h10, 32'hBEEFF344);
    go(0, 1, 2'b00, 0, 32'h15, 32'h00000077);
    wrq.push_back('{32'h15, 32'hDEAD77EF, cyc + 1});
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_rmw_write", MemWrite, 1);
    @(posedge clk);
    #1;
    rst = 0; req_read = 0; req_write = 0;
    #1;
    chk("rst_rmw_ld_data", ld_data, 0);
    chk("rst_rmw_memwrite", MemWrite, 0);
    ld(2'b10, 0, 32'h14, 32'hDEAD77EF);
    ld(2'b00, 1, 32'h15, 32'h00000077);
    sub(2'b00, 32'h10, 32'h0000005A, 32'hBEEFF35A);
    ld(2'b00, 0, 32'h10, 32'h0000005A);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("ldq_empty", ldq.size(), 0);
    chk("errq_empty", errq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
